// File: rtl/conv_col_scheduler.sv
// Column-window convolution scheduler: loads image columns into the 3x3
// datapath window, issues one convolution per output row, catches the
// fixed-latency results and streams them out through a small tagged FIFO.
module conv_col_scheduler #(
    parameter int IMG_HEIGHT  = 480,
    parameter int KERNEL_SIZE = 3,
    parameter int PIX_NB      = 19,
    parameter int CONV_LAT    = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int COL_AW      = 11
) (
    input  logic              clk100,
    input  logic              in_reset,
    input  logic              i_start,
    input  logic [COL_AW-1:0] i_img_width,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_col_req,
    output logic [COL_AW-1:0] o_col_idx,
    input  logic              i_col_ack,
    output logic              o_conv_en,
    output logic [8:0]        o_row_idx,
    input  logic [PIX_NB-1:0] i_conv_pixel,
    output logic              o_pix_valid,
    output logic [PIX_NB-1:0] o_pix_data,
    output logic [8:0]        o_pix_row,
    output logic [COL_AW-1:0] o_pix_col,
    input  logic              i_pix_ready
);

    localparam int ROW_W = 9;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int CW    = $clog2(CONV_LAT + FIFO_DEPTH + 2) + 1;
    localparam logic [ROW_W-1:0]  LAST_ROW     = ROW_W'(IMG_HEIGHT - KERNEL_SIZE);
    localparam logic [COL_AW-1:0] K_COL        = COL_AW'(KERNEL_SIZE);
    localparam logic [COL_AW-1:0] PREFILL_LAST = COL_AW'(KERNEL_SIZE - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    logic [COL_AW-1:0]  r_width;
    logic [COL_AW-1:0]  r_col;
    logic [ROW_W-1:0]   r_row;
    logic               r_busy;
    logic               r_done;
    logic               r_col_req;
    logic [COL_AW-1:0]  r_col_idx;
    logic               r_conv_en;
    logic [ROW_W-1:0]   r_row_idx;
    logic [COL_AW-1:0]  r_conv_col;

    logic [CONV_LAT-1:0] w_dl_valid;
    logic                w_push;
    logic [ROW_W-1:0]    w_push_row;
    logic [COL_AW-1:0]   w_push_col;

    logic [PIX_NB-1:0]  r_mem_data [FIFO_DEPTH];
    logic [ROW_W-1:0]   r_mem_row  [FIFO_DEPTH];
    logic [COL_AW-1:0]  r_mem_col  [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_fifo_count;

    logic               w_fifo_valid;
    logic               w_pop;
    logic [CW-1:0]      w_inflight;
    logic [CW-1:0]      w_outstanding;
    logic               w_credit;

    // Delay line tracking issued convolutions until their result arrives;
    // stage 0 is fed by the registered o_conv_en and its tags.
    for (genvar gi = 0; gi < CONV_LAT; gi++) begin : g_dl
        logic              r_valid;
        logic [ROW_W-1:0]  r_row_tag;
        logic [COL_AW-1:0] r_col_tag;
        if (gi == 0) begin : g_head
            // First stage captures the issue currently on o_conv_en
            always_ff @(posedge clk100) begin
                if (in_reset) begin
                    r_valid   <= 1'b0;
                    r_row_tag <= '0;
                    r_col_tag <= '0;
                end else begin
                    r_valid   <= r_conv_en;
                    r_row_tag <= r_row_idx;
                    r_col_tag <= r_conv_col;
                end
            end
        end else begin : g_tail
            // Later stages simply shift the previous stage along
            always_ff @(posedge clk100) begin
                if (in_reset) begin
                    r_valid   <= 1'b0;
                    r_row_tag <= '0;
                    r_col_tag <= '0;
                end else begin
                    r_valid   <= g_dl[gi-1].r_valid;
                    r_row_tag <= g_dl[gi-1].r_row_tag;
                    r_col_tag <= g_dl[gi-1].r_col_tag;
                end
            end
        end
        assign w_dl_valid[gi] = r_valid;
    end

    assign w_push     = g_dl[CONV_LAT-1].r_valid;
    assign w_push_row = g_dl[CONV_LAT-1].r_row_tag;
    assign w_push_col = g_dl[CONV_LAT-1].r_col_tag;

    assign w_fifo_valid = (r_fifo_count != '0);
    assign w_pop        = w_fifo_valid & i_pix_ready;

    // Credit check: everything issued but not yet consumed, after this
    // cycle's pop, must leave room for one more result in the FIFO.
    always_comb begin
        w_inflight = CW'(r_conv_en);
        for (int i = 0; i < CONV_LAT; i++) begin
            w_inflight = w_inflight + CW'(w_dl_valid[i]);
        end
        w_outstanding = w_inflight + CW'(r_fifo_count) - CW'(w_pop);
        w_credit      = (w_outstanding < CW'(FIFO_DEPTH));
    end

    // Result storage written on delay-line arrival; no reset needed as the
    // head is masked by the count.
    always_ff @(posedge clk100) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= i_conv_pixel;
            r_mem_row[r_wr_ptr]  <= w_push_row;
            r_mem_col[r_wr_ptr]  <= w_push_col;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge clk100) begin
        if (in_reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + CNT_W'(1);
                2'b01:   r_fifo_count <= r_fifo_count - CNT_W'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // Control FSM: column loading, row issue with credits, drain and completion
    always_ff @(posedge clk100) begin
        if (in_reset) begin
            r_state    <= S_IDLE;
            r_width    <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_col_req  <= 1'b0;
            r_col_idx  <= '0;
            r_conv_en  <= 1'b0;
            r_row_idx  <= '0;
            r_conv_col <= '0;
        end else begin
            r_done    <= 1'b0;
            r_conv_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_width <= i_img_width;
                        r_busy  <= 1'b1;
                        r_col   <= '0;
                        r_state <= (i_img_width < K_COL) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_col_req) begin
                        if (i_col_ack) begin
                            r_col_req <= 1'b0;
                            if (r_col < PREFILL_LAST) begin
                                r_col <= r_col + COL_AW'(1);
                            end else begin
                                r_row   <= '0;
                                r_state <= S_COMPUTE;
                            end
                        end
                    end else if (w_inflight == '0) begin
                        // Only shift the window once no result depends on it
                        r_col_req <= 1'b1;
                        r_col_idx <= r_col;
                    end
                end
                S_COMPUTE: begin
                    if (w_credit) begin
                        r_conv_en  <= 1'b1;
                        r_row_idx  <= r_row;
                        r_conv_col <= r_col - PREFILL_LAST;
                        r_row      <= r_row + ROW_W'(1);
                        if (r_row == LAST_ROW) begin
                            if (r_col == r_width - COL_AW'(1)) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_col   <= r_col + COL_AW'(1);
                                r_state <= S_LOAD;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if ((w_inflight == '0) && !w_fifo_valid) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_col_req   = r_col_req;
    assign o_col_idx   = r_col_idx;
    assign o_conv_en   = r_conv_en;
    assign o_row_idx   = r_row_idx;
    assign o_pix_valid = w_fifo_valid;
    assign o_pix_data  = w_fifo_valid ? r_mem_data[r_rd_ptr] : '0;
    assign o_pix_row   = w_fifo_valid ? r_mem_row[r_rd_ptr]  : '0;
    assign o_pix_col   = w_fifo_valid ? r_mem_col[r_rd_ptr]  : '0;

endmodule

// File: tb/tb_conv_col_scheduler.sv
// Bench for conv_col_scheduler: behavioural column loader, datapath and
// consumer around the DUT; expected pixels are queued when a run starts and
// a monitor compares them as the DUT hands them out.
module tb_conv_col_scheduler;

    localparam int H      = 480;
    localparam int K      = 3;
    localparam int PIX_NB = 19;
    localparam int LAT    = 2;
    localparam int DEPTH  = 4;
    localparam int COL_AW = 11;

    logic              clk100 = 1'b0;
    logic              in_reset;
    logic              i_start;
    logic [COL_AW-1:0] i_img_width;
    logic              o_busy;
    logic              o_done;
    logic              o_col_req;
    logic [COL_AW-1:0] o_col_idx;
    logic              i_col_ack;
    logic              o_conv_en;
    logic [8:0]        o_row_idx;
    logic [PIX_NB-1:0] i_conv_pixel;
    logic              o_pix_valid;
    logic [PIX_NB-1:0] o_pix_data;
    logic [8:0]        o_pix_row;
    logic [COL_AW-1:0] o_pix_col;
    logic              i_pix_ready;

    conv_col_scheduler #(
        .IMG_HEIGHT(H), .KERNEL_SIZE(K), .PIX_NB(PIX_NB),
        .CONV_LAT(LAT), .FIFO_DEPTH(DEPTH), .COL_AW(COL_AW)
    ) dut (
        .clk100(clk100), .in_reset(in_reset), .i_start(i_start),
        .i_img_width(i_img_width), .o_busy(o_busy), .o_done(o_done),
        .o_col_req(o_col_req), .o_col_idx(o_col_idx), .i_col_ack(i_col_ack),
        .o_conv_en(o_conv_en), .o_row_idx(o_row_idx), .i_conv_pixel(i_conv_pixel),
        .o_pix_valid(o_pix_valid), .o_pix_data(o_pix_data), .o_pix_row(o_pix_row),
        .o_pix_col(o_pix_col), .i_pix_ready(i_pix_ready)
    );

    always #5 clk100 = ~clk100;

    typedef struct {
        int data;
        int row;
        int col;
    } pix_t;

    pix_t sb_q[$];
    int   col_log[$];

    int n_checks = 0;
    int n_fail   = 0;

    // environment state shared between stimulus and the negedge driver
    int cyc = 0;
    int sched_val[8];
    bit sched_v[8];
    int win[3];
    int req_cnt = 0;
    int req_idx = 0;
    int ack_delay = 0;
    int ready_mode = 0;      // 0: always ready, 1: held low, 2: toggling
    int emitted = 0;
    int conv_cnt = 0;
    int done_cnt = 0;
    int first_conv = -1;
    int first_pix = -1;
    bit prev_hold = 1'b0;
    logic [PIX_NB-1:0] prev_data;
    logic [8:0]        prev_row;
    logic [COL_AW-1:0] prev_col;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Environment: datapath with fixed latency, column loader, consumer and monitor
    always @(negedge clk100) begin
        int pend;
        int slot;
        pix_t e;
        cyc++;
        slot = cyc % 8;

        pend = 0;
        for (int k = 0; k < 8; k++) pend += int'(sched_v[k]);

        // datapath: image pixel (y,x) = y + 2x, kernel all ones
        if (sched_v[slot]) begin
            i_conv_pixel  = PIX_NB'(sched_val[slot]);
            sched_v[slot] = 1'b0;
        end else begin
            i_conv_pixel = '1;
        end
        if (o_conv_en) begin
            conv_cnt++;
            if (first_conv < 0) first_conv = cyc;
            sched_val[(cyc + LAT) % 8] = 9 * int'(o_row_idx) + 9 + 6 * (win[0] + win[1] + win[2]);
            sched_v[(cyc + LAT) % 8]   = 1'b1;
        end

        // column loader with configurable ack delay
        if (o_col_req) begin
            if (req_cnt == 0) begin
                check("req_while_inflight", 64'(pend), 64'd0);
                req_idx = int'(o_col_idx);
            end else begin
                check("col_idx_stable", 64'(o_col_idx), 64'(req_idx));
            end
            if (req_cnt >= ack_delay) begin
                i_col_ack = 1'b1;
                win[0] = win[1];
                win[1] = win[2];
                win[2] = int'(o_col_idx);
                col_log.push_back(int'(o_col_idx));
            end else begin
                i_col_ack = 1'b0;
            end
            req_cnt++;
        end else begin
            req_cnt   = 0;
            i_col_ack = 1'b0;
        end

        // consumer
        case (ready_mode)
            0:       i_pix_ready = 1'b1;
            1:       i_pix_ready = 1'b0;
            default: i_pix_ready = ~i_pix_ready;
        endcase

        // monitor
        if (prev_hold) begin
            check("head_stable", {24'd0, o_pix_valid, o_pix_data, o_pix_row, o_pix_col},
                  {24'd0, 1'b1, prev_data, prev_row, prev_col});
        end
        if (o_pix_valid && i_pix_ready) begin
            emitted++;
            if (first_pix < 0) first_pix = cyc;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL extra_pixel: got row %0d col %0d, expected none", o_pix_row, o_pix_col);
            end else begin
                e = sb_q.pop_front();
                check("pix_data", 64'(o_pix_data), 64'(e.data));
                check("pix_row", 64'(o_pix_row), 64'(e.row));
                check("pix_col", 64'(o_pix_col), 64'(e.col));
            end
        end
        prev_hold = o_pix_valid && !i_pix_ready;
        prev_data = o_pix_data;
        prev_row  = o_pix_row;
        prev_col  = o_pix_col;

        if (o_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    function automatic logic [63:0] all_outputs();
        return {o_busy, o_done, o_col_req, o_col_idx, o_conv_en, o_row_idx,
                o_pix_valid, o_pix_data, o_pix_row, o_pix_col};
    endfunction

    task automatic start_run(input int w);
        emitted = 0; conv_cnt = 0; done_cnt = 0;
        first_conv = -1; first_pix = -1;
        col_log.delete();
        for (int c = 0; c <= w - K; c++) begin
            for (int r = 0; r <= H - K; r++) begin
                pix_t p;
                p.data = 9 * r + 18 * c + 27;
                p.row  = r;
                p.col  = c;
                sb_q.push_back(p);
            end
        end
        i_img_width = COL_AW'(w);
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done_cnt > 0) break;
        end
        check("done_seen", 64'(done_cnt > 0), 64'd1);
        repeat (3) tick();
    endtask

    task automatic end_checks(input int w, input int npix);
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("busy_after", 64'(o_busy), 64'd0);
        check("pix_count", 64'(emitted), 64'(npix));
        check("sb_leftover", 64'(sb_q.size()), 64'd0);
        check("col_req_count", 64'(col_log.size()), 64'((w >= K) ? w : 0));
        for (int i = 0; i < col_log.size(); i++) begin
            check("col_req_idx", 64'(col_log[i]), 64'(i));
        end
    endtask

    initial begin
        bit found;
        in_reset     = 1'b1;
        i_start      = 1'b0;
        i_img_width  = '0;
        i_col_ack    = 1'b0;
        i_pix_ready  = 1'b1;
        i_conv_pixel = '0;
        for (int k = 0; k < 8; k++) sched_v[k] = 1'b0;
        for (int k = 0; k < 3; k++) win[k] = 0;

        repeat (3) tick();
        check("reset_outputs", all_outputs(), 64'd0);
        in_reset = 1'b0;
        tick();

        // full throughput, W=5
        ready_mode = 0; ack_delay = 0;
        start_run(5);
        wait_done(4000);
        end_checks(5, 1434);
        check("first_pix_latency", 64'(first_pix - first_conv), 64'(LAT + 1));

        // consumer stalled: exactly DEPTH issues, then release
        ready_mode = 1;
        start_run(3);
        repeat (60) tick();
        check("stall_issue_count", 64'(conv_cnt), 64'(DEPTH));
        check("stall_head_valid", 64'(o_pix_valid), 64'd1);
        ready_mode = 0;
        wait_done(3000);
        end_checks(3, 478);
        check("total_issues", 64'(conv_cnt), 64'd478);

        // slow column loader
        ack_delay = 7;
        start_run(4);
        wait_done(4000);
        end_checks(4, 956);
        ack_delay = 0;

        // narrow image: straight to done
        start_run(2);
        check("w2_busy", 64'(o_busy), 64'd1);
        check("w2_done_early", 64'(o_done), 64'd0);
        tick();
        check("w2_done", 64'(o_done), 64'd1);
        check("w2_busy_low", 64'(o_busy), 64'd0);
        repeat (3) tick();
        end_checks(2, 0);

        // reset in the middle of column 3's computation
        start_run(5);
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (o_conv_en && o_row_idx == 9'd100 && win[2] == 3) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_col3", 64'(found), 64'd1);
        in_reset = 1'b1;
        tick();
        check("midrun_reset_outputs", all_outputs(), 64'd0);
        sb_q.delete();
        for (int k = 0; k < 8; k++) sched_v[k] = 1'b0;
        in_reset = 1'b0;
        tick();
        start_run(4);
        wait_done(4000);
        end_checks(4, 956);

        // toggling consumer and a start pulse while busy
        ready_mode = 2;
        start_run(3);
        repeat (20) tick();
        i_img_width = COL_AW'(5);
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
        wait_done(4000);
        end_checks(3, 478);
        ready_mode = 0;

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
